// File: rtl/vga_axil_slave_fsm.sv
// AXI-Lite slave to native word bus: independent write/read FSMs, bvalid 2 cycles after last AW/W handshake, rvalid 3 cycles after AR.
// Responses hold until bready/rready; define VGA_AXIL_SLVERR_EN to answer misaligned addresses with SLVERR and no native strobe.
module vga_axil_slave_fsm #(
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32,
  localparam int AXIL_WIDTH_OFFSET = $clog2(AXIL_DATA_WIDTH / 8)
) (
  input  logic                                         clk,
  input  logic                                         arst_n,
  // write address
  input  logic [AXIL_ADDR_WIDTH-1:0]                   awaddr,
  input  logic [2:0]                                   awprot,
  input  logic                                         awvalid,
  output logic                                         awready,
  // write data
  input  logic [AXIL_DATA_WIDTH-1:0]                   wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0]                 wstrb,
  input  logic                                         wvalid,
  output logic                                         wready,
  // write response
  output logic [1:0]                                   bresp,
  output logic                                         bvalid,
  input  logic                                         bready,
  // read address
  input  logic [AXIL_ADDR_WIDTH-1:0]                   araddr,
  input  logic [2:0]                                   arprot,
  input  logic                                         arvalid,
  output logic                                         arready,
  // read data
  output logic [AXIL_DATA_WIDTH-1:0]                   rdata,
  output logic [1:0]                                   rresp,
  output logic                                         rvalid,
  input  logic                                         rready,
  // native write
  output logic                                         write_en,
  output logic [AXIL_ADDR_WIDTH-AXIL_WIDTH_OFFSET-1:0] addr_write,
  output logic [AXIL_DATA_WIDTH-1:0]                   data2native,
  // native read
  output logic                                         read_en_sync,
  output logic [AXIL_ADDR_WIDTH-AXIL_WIDTH_OFFSET-1:0] addr_read,
  input  logic [AXIL_DATA_WIDTH-1:0]                   data2axil
);

  localparam int NAW = AXIL_ADDR_WIDTH - AXIL_WIDTH_OFFSET;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef VGA_AXIL_SLVERR_EN
  localparam bit SlvErrEn = 1'b1;
`else
  localparam bit SlvErrEn = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_CAPTURE, R_RESP} r_state_e;

  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, wstrb};

  // ---------------------------------------------------------------- write
  w_state_e                   w_state_q, w_state_d;
  logic                       aw_got_q, aw_got_d;
  logic                       w_got_q, w_got_d;
  logic                       aw_err_q, aw_err_d;
  logic                       awready_q, awready_d;
  logic                       wready_q, wready_d;
  logic                       write_en_q, write_en_d;
  logic [NAW-1:0]             addr_write_q, addr_write_d;
  logic [AXIL_DATA_WIDTH-1:0] data2native_q, data2native_d;
  logic                       bvalid_q, bvalid_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic                       aw_hs, w_hs;

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;

  always_comb begin
    w_state_d     = w_state_q;
    aw_got_d      = aw_got_q;
    w_got_d       = w_got_q;
    aw_err_d      = aw_err_q;
    awready_d     = awready_q;
    wready_d      = wready_q;
    write_en_d    = 1'b0;
    addr_write_d  = addr_write_q;
    data2native_d = data2native_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d     = 1'b1;
          addr_write_d = awaddr[AXIL_ADDR_WIDTH-1:AXIL_WIDTH_OFFSET];
          aw_err_d     = SlvErrEn && (|awaddr[AXIL_WIDTH_OFFSET-1:0]);
        end
        if (w_hs) begin
          w_got_d       = 1'b1;
          data2native_d = wdata;
        end
        // AW and W may arrive in either order; launch once both are held
        if (aw_got_d && w_got_d) begin
          w_state_d  = W_WRITE;
          write_en_d = !aw_err_d;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
        end else begin
          awready_d = !aw_got_d;
          wready_d  = !w_got_d;
        end
      end
      W_WRITE: begin
        w_state_d = W_RESP;
        bvalid_d  = 1'b1;
        bresp_d   = aw_err_q ? RESP_SLVERR : RESP_OKAY;
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          aw_err_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      w_state_q     <= W_IDLE;
      aw_got_q      <= 1'b0;
      w_got_q       <= 1'b0;
      aw_err_q      <= 1'b0;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      write_en_q    <= 1'b0;
      addr_write_q  <= '0;
      data2native_q <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
    end else begin
      w_state_q     <= w_state_d;
      aw_got_q      <= aw_got_d;
      w_got_q       <= w_got_d;
      aw_err_q      <= aw_err_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      write_en_q    <= write_en_d;
      addr_write_q  <= addr_write_d;
      data2native_q <= data2native_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
    end
  end

  // ---------------------------------------------------------------- read
  r_state_e                   r_state_q, r_state_d;
  logic                       r_err_q, r_err_d;
  logic                       arready_q, arready_d;
  logic                       read_en_q, read_en_d;
  logic [NAW-1:0]             addr_read_q, addr_read_d;
  logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic                       rvalid_q, rvalid_d;
  logic                       ar_hs;

  assign ar_hs = arvalid & arready_q;

  always_comb begin
    r_state_d   = r_state_q;
    r_err_d     = r_err_q;
    arready_d   = arready_q;
    read_en_d   = 1'b0;
    addr_read_d = addr_read_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rvalid_d    = rvalid_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = !ar_hs;
        if (ar_hs) begin
          r_state_d   = R_READ;
          addr_read_d = araddr[AXIL_ADDR_WIDTH-1:AXIL_WIDTH_OFFSET];
          r_err_d     = SlvErrEn && (|araddr[AXIL_WIDTH_OFFSET-1:0]);
          read_en_d   = !r_err_d;
        end
      end
      R_READ: r_state_d = R_CAPTURE;
      // native data is valid the cycle after the read strobe
      R_CAPTURE: begin
        r_state_d = R_RESP;
        rdata_d   = r_err_q ? '0 : data2axil;
        rresp_d   = r_err_q ? RESP_SLVERR : RESP_OKAY;
        rvalid_d  = 1'b1;
      end
      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          r_err_d   = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state_q   <= R_IDLE;
      r_err_q     <= 1'b0;
      arready_q   <= 1'b0;
      read_en_q   <= 1'b0;
      addr_read_q <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      r_err_q     <= r_err_d;
      arready_q   <= arready_d;
      read_en_q   <= read_en_d;
      addr_read_q <= addr_read_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign write_en     = write_en_q;
  assign addr_write   = addr_write_q;
  assign data2native  = data2native_q;
  assign arready      = arready_q;
  assign read_en_sync = read_en_q;
  assign addr_read    = addr_read_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign rvalid       = rvalid_q;

endmodule

// File: tb/tb_vga_axil_slave_fsm.sv
// Directed bench for vga_axil_slave_fsm with a word-addressed backing store on the native side.
module tb_vga_axil_slave_fsm;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        write_en;
  logic [29:0] addr_write;
  logic [31:0] data2native;
  logic        read_en_sync;
  logic [29:0] addr_read;
  logic [31:0] data2axil;

  localparam logic [1:0] OKAY = 2'b00;
`ifdef VGA_AXIL_SLVERR_EN
  localparam logic [1:0] MIS_RESP = 2'b10;
`else
  localparam logic [1:0] MIS_RESP = 2'b00;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  logic [31:0] mem [0:15];

  vga_axil_slave_fsm dut (
    .clk(clk), .arst_n(arst_n),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .write_en(write_en), .addr_write(addr_write), .data2native(data2native),
    .read_en_sync(read_en_sync), .addr_read(addr_read), .data2axil(data2axil)
  );

  always #5 clk = ~clk;

  // native side: store on write_en, return data one cycle after read_en_sync, garbage otherwise
  always @(posedge clk) begin
    if (write_en) begin
      mem[addr_write[3:0]] <= data2native;
      we_cnt <= we_cnt + 1;
    end
    if (read_en_sync) re_cnt <= re_cnt + 1;
    data2axil <= read_en_sync ? mem[addr_read[3:0]] : 32'hDEAD_BEEF;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // mode 0: AW and W together, 1: AW first, 2: W first
  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input int mode,
                            input int hold, input logic [1:0] exp_resp);
    int   we0;
    logic strobe;
    we0    = we_cnt;
    strobe = (exp_resp == OKAY);
    awaddr = addr;
    wdata  = data;
    if (mode == 0) begin
      awvalid = 1'b1; wvalid = 1'b1;
      check_eq("awready_idle", awready, 1);
      check_eq("wready_idle", wready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
    end else if (mode == 1) begin
      awvalid = 1'b1;
      check_eq("awready_idle", awready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      check_eq("awready_after_aw", awready, 0);
      check_eq("we_early", write_en, 0);
      wvalid = 1'b1;
      check_eq("wready_wait", wready, 1);
      @(posedge clk); #1;
      wvalid = 1'b0;
    end else begin
      wvalid = 1'b1;
      check_eq("wready_idle", wready, 1);
      @(posedge clk); #1;
      wvalid = 1'b0;
      check_eq("wready_after_w", wready, 0);
      check_eq("we_early", write_en, 0);
      awvalid = 1'b1;
      check_eq("awready_wait", awready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0;
    end
    check_eq("write_en", write_en, strobe);
    if (strobe) begin
      check_eq("addr_write", addr_write, addr >> 2);
      check_eq("data2native", data2native, data);
    end
    check_eq("bvalid_early", bvalid, 0);
    @(posedge clk); #1;
    check_eq("bvalid", bvalid, 1);
    check_eq("bresp", bresp, exp_resp);
    check_eq("write_en_1cyc", write_en, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("bvalid_hold", bvalid, 1);
      check_eq("bresp_hold", bresp, exp_resp);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_eq("bvalid_clr", bvalid, 0);
    check_eq("awready_back", awready, 1);
    check_eq("we_pulses", we_cnt - we0, strobe);
  endtask

  task automatic axil_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input int hold, input logic [1:0] exp_resp);
    int   re0;
    logic strobe;
    re0     = re_cnt;
    strobe  = (exp_resp == OKAY);
    araddr  = addr;
    arvalid = 1'b1;
    check_eq("arready_idle", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check_eq("arready_busy", arready, 0);
    check_eq("read_en_sync", read_en_sync, strobe);
    if (strobe) check_eq("addr_read", addr_read, addr >> 2);
    @(posedge clk); #1;
    check_eq("read_en_1cyc", read_en_sync, 0);
    check_eq("rvalid_early", rvalid, 0);
    @(posedge clk); #1;
    check_eq("rvalid", rvalid, 1);
    check_eq("rresp", rresp, exp_resp);
    check_eq("rdata", rdata, exp_data);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("rvalid_hold", rvalid, 1);
      check_eq("rresp_hold", rresp, exp_resp);
      check_eq("rdata_hold", rdata, exp_data);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check_eq("rvalid_clr", rvalid, 0);
    check_eq("arready_back", arready, 1);
    check_eq("re_pulses", re_cnt - re0, strobe);
  endtask

  initial begin
    int          we0, re0;
    logic [31:0] a, d;
    #12;
    check_eq("rst_awready", awready, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_arready", arready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_write_en", write_en, 0);
    check_eq("rst_read_en", read_en_sync, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_addr_write", addr_write, 0);
    check_eq("rst_bresp", bresp, 0);
    #10 arst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_awready", awready, 1);
    check_eq("rel_wready", wready, 1);
    check_eq("rel_arready", arready, 1);

    // continuous writes of data = addr, mixed AW/W ordering, then read back
    for (int i = 0; i < 10; i++)
      axil_write(32'(i * 4), 32'(i * 4), i % 3, (i == 3) ? 5 : 0, OKAY);
    for (int i = 0; i < 10; i++)
      axil_read(32'(i * 4), 32'(i * 4), (i == 4) ? 5 : 0, OKAY);

    // concurrent write and read with no mutual stall
    fork
      axil_write(32'h28, 32'hA5A5_0028, 0, 0, OKAY);
      axil_read(32'h8, 32'h8, 0, OKAY);
    join
    axil_read(32'h28, 32'hA5A5_0028, 0, OKAY);

    // misaligned address 0x6
    axil_write(32'h6, 32'h1234_5678, 0, 0, MIS_RESP);
`ifdef VGA_AXIL_SLVERR_EN
    axil_read(32'h6, 32'h0, 0, MIS_RESP);
    axil_read(32'h4, 32'h4, 0, OKAY);
`else
    axil_read(32'h6, 32'h1234_5678, 0, OKAY);
    axil_read(32'h4, 32'h1234_5678, 0, OKAY);
`endif

    // reset mid-write (AW captured, W pending) with traffic offered during reset
    @(posedge clk); #1;
    awaddr = 32'h3C; wdata = 32'h0BAD_0BAD; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    we0 = we_cnt; re0 = re_cnt;
    arst_n = 1'b0;
    wvalid = 1'b1; arvalid = 1'b1; araddr = 32'h10;
    #30;
    check_eq("mid_rst_awready", awready, 0);
    check_eq("mid_rst_wready", wready, 0);
    check_eq("mid_rst_arready", arready, 0);
    check_eq("mid_rst_bvalid", bvalid, 0);
    check_eq("mid_rst_rvalid", rvalid, 0);
    wvalid = 1'b0; arvalid = 1'b0;
    #30 arst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_awready", awready, 1);
    check_eq("post_rst_wready", wready, 1);
    check_eq("post_rst_arready", arready, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_bvalid", bvalid, 0);
    check_eq("post_rst_rvalid", rvalid, 0);
    check_eq("post_rst_no_we", we_cnt - we0, 0);
    check_eq("post_rst_no_re", re_cnt - re0, 0);

    // random aligned traffic after reset
    for (int i = 0; i < 10; i++) begin
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      axil_write(a, d, int'($urandom_range(0, 2)), 0, OKAY);
      axil_read(a, d, 0, OKAY);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_axil_slave_fsm.md
VGA_AXIL_SLAVE_FSM -- requirements
Module: vga_axil_slave_fsm

Interface
REQ-001 Clocking: the block SHALL use one clock, clk; reset is asynchronous and active-low, arst_n.
REQ-002 Parameter AXIL_ADDR_WIDTH, default 32: width of the AXI-Lite byte address.
REQ-003 Parameter AXIL_DATA_WIDTH, default 32: data width; AXIL_WIDTH_OFFSET = log2(AXIL_DATA_WIDTH/8) = 2.
REQ-004 Port clk  in  1  system clock.
REQ-005 Port arst_n  in  1  asynchronous active-low reset.
REQ-006 AXI-Lite write address: awaddr in ADDR, awprot in 3 (ignored), awvalid in 1, awready out 1.
REQ-007 AXI-Lite write data: wdata in DATA, wstrb in DATA/8 (ignored; full-word writes), wvalid in 1, wready out 1.
REQ-008 AXI-Lite write response: bresp out 2, bvalid out 1, bready in 1.
REQ-009 AXI-Lite read address: araddr in ADDR, arprot in 3 (ignored), arvalid in 1, arready out 1.
REQ-010 AXI-Lite read data: rdata out DATA, rresp out 2, rvalid out 1, rready in 1.
REQ-011 Native write: write_en out 1, addr_write out ADDR-2, data2native out DATA.
REQ-012 Native read: read_en_sync out 1, addr_read out ADDR-2, data2axil in DATA, valid one cycle after read_en_sync.

Function
REQ-013 Native address SHALL be axil_addr >> AXIL_WIDTH_OFFSET (word address); low 2 bits are dropped.
REQ-014 Write and read FSMs SHALL be fully independent and operate concurrently without mutual stalling.
REQ-015 Write FSM states: W_IDLE, W_WRITE, W_RESP.
REQ-016 In W_IDLE, awready = 1 until AW is captured and wready = 1 until W is captured; AW and W are accepted in either order or in the same cycle.
REQ-017 When both AW and W are captured, the FSM SHALL go to W_WRITE, driving write_en = 1 for exactly one cycle with the registered addr_write/data2native.
REQ-018 W_WRITE SHALL always go to W_RESP: bvalid = 1, bresp = OKAY (2'b00), held until bready; then return to W_IDLE. awready/wready = 0 outside W_IDLE.
REQ-019 Read FSM states: R_IDLE, R_READ, R_CAPTURE, R_RESP.
REQ-020 In R_IDLE, arready = 1; an arvalid handshake SHALL register addr_read and go to R_READ.
REQ-021 R_READ: read_en_sync = 1 for exactly one cycle. R_CAPTURE: rdata <= data2axil.
REQ-022 R_RESP: rvalid = 1, rresp = OKAY, rdata held stable until rready; then return to R_IDLE.
REQ-023 Latency: read handshake to rvalid = 3 cycles; completion of the second of AW/W to bvalid = 2 cycles.
REQ-024 Outputs SHALL be registered; valid/data SHALL NOT change while valid = 1 and ready = 0.

Reset
REQ-025 On arst_n = 0, both FSMs SHALL go to idle immediately: awready = wready = arready = 0 during reset, and 1 on the first cycle after release.
REQ-026 bvalid, rvalid, write_en and read_en_sync SHALL be 0; addresses, data and resp fields SHALL be 0.
REQ-027 Reset mid-transaction SHALL drop the transaction silently: no native strobe and no response.

Configuration
REQ-028 With macro VGA_AXIL_SLVERR_EN defined, an address with nonzero low AXIL_WIDTH_OFFSET bits SHALL suppress write_en/read_en_sync and return SLVERR (2'b10), with rdata = 0 for reads.
REQ-029 Without VGA_AXIL_SLVERR_EN, the low bits are ignored and the response is always OKAY.

Verification
REQ-030 Continuous: write addr 0x0,0x4,...,0x24 with data = addr, then read the same addresses -> every bresp/rresp = OKAY, rdata = written data, addr_write = 0..9.
REQ-031 Parallel: random-aligned write and read issued in the same cycle -> both complete with OKAY; read returns the backing-store value; no stall.
REQ-032 AW one cycle before W, and W before AW -> single write_en pulse with correct addr/data; bvalid 2 cycles after the last handshake.
REQ-033 Backpressure: hold bready/rready = 0 for 5 cycles -> bvalid/rvalid, bresp/rresp and rdata stay stable; no new native strobes.
REQ-034 Assert arst_n = 0 for 50-100 ns during random traffic -> all valids drop to 0, no strobes; a subsequent random test of 10 writes/reads passes.
REQ-035 With VGA_AXIL_SLVERR_EN defined, write/read to 0x6 -> SLVERR, no write_en/read_en_sync; without the macro -> OKAY at native addr 0x1.
